// File: rtl/bus_serial_tx_if.sv
// bus_serial_tx_if: parallel word handshake in, framed serial bit stream out.
// master is the side that offers words; slave is the serializer.
interface bus_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out;
    logic             out_valid;
    logic             out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/bus_serial_tx.sv
// bus_serial_tx: one-word buffer feeding a shift register, so words
// leave back-to-back; bit order chosen by LSB_FIRST.
module bus_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    bus_serial_tx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic accept;
    logic at_end;
    logic load;

    // Bit that leaves first from a word (or from the remaining shift bits).
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Remaining bits once the head bit has been sent.
    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // in_ready depends only on registered state, never on in_valid.
    assign bus.in_ready = !buf_full;
    assign accept       = bus.in_valid && !buf_full;
    assign at_end       = (state == SHIFT) && (cnt == LAST);
    // The buffer drains into the shifter when idle or on a word's last edge.
    assign load         = buf_full && ((state == IDLE) || at_end);

    // Holding buffer: filled on accept, emptied when the shifter takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_data <= bus.in_data;
            buf_full <= 1'b1;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    // Shift FSM with registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sr            <= '0;
            cnt           <= '0;
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (buf_full) begin
                        state         <= SHIFT;
                        sr            <= tail(buf_data);
                        cnt           <= '0;
                        bus.out       <= head(buf_data);
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (buf_full) begin
                            sr            <= tail(buf_data);
                            bus.out       <= head(buf_data);
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= 1'b0;
                        end else begin
                            state         <= IDLE;
                            sr            <= '0;
                            bus.out       <= 1'b0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end
                    end else begin
                        cnt          <= cnt + 1'b1;
                        sr           <= tail(sr);
                        bus.out      <= head(sr);
                        bus.out_last <= (cnt == PENULT);
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out       <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_serial_tx.sv
// tb_bus_serial_tx: three serializers (8 LSB-first, 8 MSB-first, 2 LSB-first)
// compared each cycle against a word-schedule reference model.
module tb_bus_serial_tx;
    localparam int NI = 3;
    localparam int MAXW = 512;
    localparam int WID [NI] = '{8, 8, 2};
    localparam bit LSB [NI] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bus_serial_tx_if #(.WIDTH(8)) if0 ();
    bus_serial_tx_if #(.WIDTH(8)) if1 ();
    bus_serial_tx_if #(.WIDTH(2)) if2 ();

    bus_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    bus_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    bus_serial_tx #(.WIDTH(2), .LSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    logic [2:0]  v;
    logic [31:0] d [NI];
    logic [2:0]  r_ready, r_out, r_v, r_l;

    assign if0.in_valid = v[0];
    assign if1.in_valid = v[1];
    assign if2.in_valid = v[2];
    assign if0.in_data  = d[0][7:0];
    assign if1.in_data  = d[1][7:0];
    assign if2.in_data  = d[2][1:0];
    assign r_ready = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign r_out   = {if2.out, if1.out, if0.out};
    assign r_v     = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign r_l     = {if2.out_last, if1.out_last, if0.out_last};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model: each accepted word gets a start edge; its bits
    // occupy edges start..start+W-1
    int          st [NI][MAXW];
    logic [31:0] wd [NI][MAXW];
    int          nw [NI];
    int          s_last [NI];
    int          busy [NI];

    // stimulus queues and handshake hold flags
    logic [31:0] stim [NI][MAXW];
    int          sh [NI];
    int          sn [NI];
    bit          hold [NI];
    bit          dense;

    // serial bits seen on the wire, first bit ends up most significant
    logic [63:0] col [NI];
    int          ncol [NI];

    task automatic push(input int i, input logic [31:0] w);
        stim[i][sn[i]] = w;
        sn[i]++;
    endtask

    task automatic clear_col();
        for (int i = 0; i < NI; i++) begin
            col[i] = '0;
            ncol[i] = 0;
        end
    endtask

    task automatic model_accept(input int i, input logic [31:0] w);
        int s;
        s = (cyc + 1 > busy[i]) ? cyc + 1 : busy[i];
        st[i][nw[i]] = s;
        wd[i][nw[i]] = w & ((32'd1 << WID[i]) - 32'd1);
        nw[i]++;
        busy[i] = s + WID[i];
        s_last[i] = s;
    endtask

    function automatic int cur_k(input int i, input int t);
        int lo;
        lo = (nw[i] > 4) ? nw[i] - 4 : 0;
        for (int j = lo; j < nw[i]; j++)
            if (t >= st[i][j] && t < st[i][j] + WID[i])
                return t - st[i][j];
        return -1;
    endfunction

    function automatic logic cur_bit(input int i, input int t);
        int lo;
        int k;
        lo = (nw[i] > 4) ? nw[i] - 4 : 0;
        for (int j = lo; j < nw[i]; j++) begin
            if (t >= st[i][j] && t < st[i][j] + WID[i]) begin
                k = t - st[i][j];
                return LSB[i] ? wd[i][j][k] : wd[i][j][WID[i] - 1 - k];
            end
        end
        return 1'b0;
    endfunction

    task automatic check_all();
        logic eo, ev, el, er;
        int k;
        for (int i = 0; i < NI; i++) begin
            k  = cur_k(i, cyc);
            ev = (k >= 0);
            el = (k == WID[i] - 1);
            eo = cur_bit(i, cyc);
            er = (cyc >= s_last[i]);
            vectors++;
            assert (r_ready[i] === er) else begin
                miscompares++;
                $error("FAIL in_ready[%0d] cyc=%0d got %b exp %b",
                       i, cyc, r_ready[i], er);
            end
            vectors++;
            assert (r_v[i] === ev) else begin
                miscompares++;
                $error("FAIL out_valid[%0d] cyc=%0d got %b exp %b",
                       i, cyc, r_v[i], ev);
            end
            vectors++;
            assert (r_l[i] === el) else begin
                miscompares++;
                $error("FAIL out_last[%0d] cyc=%0d got %b exp %b",
                       i, cyc, r_l[i], el);
            end
            vectors++;
            assert (r_out[i] === eo) else begin
                miscompares++;
                $error("FAIL out[%0d] cyc=%0d got %b exp %b",
                       i, cyc, r_out[i], eo);
            end
            if (r_v[i] === 1'b1) begin
                col[i] = {col[i][62:0], r_out[i]};
                ncol[i]++;
            end
        end
    endtask

    task automatic step();
        logic [2:0] acc;
        for (int i = 0; i < NI; i++)
            acc[i] = hold[i] && (rst_n === 1'b1) && (cyc >= s_last[i]);
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++)
            if (acc[i]) model_accept(i, d[i]);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) hold[i] = 1'b0;
            if (!hold[i] && sh[i] < sn[i] &&
                (dense || $urandom_range(0, 2) == 0)) begin
                d[i] = stim[i][sh[i]];
                sh[i]++;
                hold[i] = 1'b1;
            end
            if (!hold[i]) d[i] = $urandom;
            v[i] = hold[i];
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        v = '0;
        for (int i = 0; i < NI; i++) begin
            hold[i] = 1'b0;
            sh[i] = sn[i];
            nw[i] = 0;
            s_last[i] = cyc;
            busy[i] = cyc;
        end
        #1;
        check_all();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
        clear_col();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lit(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        bit found;
        int guard;
        rst_n = 1'b0;
        v = '0;
        dense = 1'b1;
        for (int i = 0; i < NI; i++) begin
            d[i] = '0;
            nw[i] = 0;
            s_last[i] = 0;
            busy[i] = 0;
            sh[i] = 0;
            sn[i] = 0;
            hold[i] = 1'b0;
        end
        clear_col();

        // reset state
        #2;
        check_all();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
        #1;
        rst_n = 1'b1;

        // single word, both bit orders; minimum width back-to-back
        clear_col();
        push(0, 32'hB4);
        push(1, 32'hB4);
        push(2, 32'h1);
        push(2, 32'h2);
        repeat (14) step();
        lit("lsb_b4", col[0], 64'b00101101);
        lit("msb_b4", col[1], 64'b10110100);
        lit("w2_01_10", col[2], 64'b1001);
        lit("lsb_b4_n", 64'(ncol[0]), 64'd8);
        lit("w2_n", 64'(ncol[2]), 64'd4);

        // back-to-back FF then 00
        clear_col();
        push(0, 32'hFF);
        push(0, 32'h00);
        push(1, 32'hFF);
        push(1, 32'h00);
        push(2, 32'h3);
        push(2, 32'h0);
        repeat (24) step();
        lit("b2b_lsb", col[0], 64'hFF00);
        lit("b2b_msb", col[1], 64'hFF00);
        lit("b2b_n", 64'(ncol[0]), 64'd16);

        // backpressure: three words queued
        clear_col();
        push(0, 32'h11);
        push(0, 32'h22);
        push(0, 32'h33);
        push(1, 32'hC3);
        push(1, 32'h5A);
        push(1, 32'h0F);
        repeat (32) step();
        lit("bp_msb", col[1], 64'hC35A0F);
        lit("bp_n", 64'(ncol[0]), 64'd24);

        // async reset while bit 3 of A5 is on the wire
        clear_col();
        push(0, 32'hA5);
        push(1, 32'hA5);
        push(2, 32'h2);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 30) begin
            step();
            found = (cur_k(0, cyc) == 3);
            guard++;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL wait_bit3 got %0d exp 3", cur_k(0, cyc));
        end
        async_reset();
        push(0, 32'h3C);
        push(1, 32'h3C);
        repeat (14) step();
        lit("rst_3c_lsb", col[0], 64'b00111100);
        lit("rst_3c_msb", col[1], 64'h3C);
        lit("rst_3c_n", 64'(ncol[0]), 64'd8);

        // random words with sparse valid
        dense = 1'b0;
        for (int n = 0; n < 30; n++) begin
            push(0, $urandom);
            push(1, $urandom);
        end
        for (int n = 0; n < 60; n++) push(2, $urandom);
        repeat (400) step();

        // random words with valid held high
        dense = 1'b1;
        for (int n = 0; n < 20; n++)
            for (int i = 0; i < NI; i++) push(i, $urandom);
        repeat (200) step();

        // drain everything still queued or in flight
        guard = 0;
        while (guard < 400 &&
               (hold[0] || hold[1] || hold[2] ||
                sh[0] < sn[0] || sh[1] < sn[1] || sh[2] < sn[2] ||
                cyc < busy[0] || cyc < busy[1] || cyc < busy[2])) begin
            step();
            guard++;
        end
        vectors++;
        assert (guard < 400) else begin
            miscompares++;
            $error("FAIL drain got %0d cycles exp <400", guard);
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_serial_tx.md
# bus_serial_tx

Word-to-bit serializer that drives one serial data line plus framing strobes into a downstream chain of capture flops. It is the transmit end of the serial bus that our register-chain test designs capture bit by bit. It accepts parallel words over a valid/ready handshake and holds one word in a buffer while shifting another, so back-to-back words leave with no idle cycle. Bit order is a parameter, so both ascending and descending bus orders can be driven from the same block.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- LSB_FIRST, 1, 1: in_data[0] goes out first; 0: in_data[WIDTH-1] goes out first.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word; sampled on accept.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can take a word; equals NOT buf_full.
- out  output  1  serial data bit, registered.
- out_valid  output  1  out carries a live bit this cycle, registered.
- out_last  output  1  current bit is the final bit of its word, registered.

## Operation
- Storage:
  - one-word buffer buf plus flag buf_full;
  - shift register sr (WIDTH bits);
  - bit counter cnt (ceil(log2 WIDTH) bits);
  - state SHIFT flag, with IDLE being its complement.
- Accept: on any rising edge where in_valid=1 and in_ready=1, capture in_data into buf and set buf_full. in_ready is a decode of the registered buf_full, with no combinational path from in_valid.
- IDLE, buf_full=1: at the next edge, move buf into sr, clear buf_full, set cnt=0, enter SHIFT. Drive out with the first bit, out_valid=1, and out_last=0.
- SHIFT, cnt<WIDTH-1: each edge advances one bit and increments cnt. out_last=1 exactly while cnt=WIDTH-1.
- SHIFT, final edge (cnt=WIDTH-1):
  - buf_full=1: reload sr from buf, clear buf_full, set cnt=0, stay in SHIFT. The first bit of the next word follows with no gap.
  - buf_full=0: go to IDLE; out_valid, out_last, and out all become 0.
- Accept and buffer drain never coincide. in_ready=0 whenever buf_full=1, and a drain clears buf_full for the following cycle.
- The data content is not interpreted and all words are forwarded unchanged. out is forced to 0 whenever out_valid=0.

## Timing
- Reset (rst_n=0) takes effect immediately, without waiting for a clock edge:
  - out=0, out_valid=0, out_last=0;
  - buf_full=0, so in_ready=1;
  - cnt=0, state IDLE.
- Releasing reset starts operation from the first rising edge with rst_n=1.
- Reset mid-word: the word in flight and the buffered word are both discarded. No partial frame resumes after reset.
- Latency: a word accepted at edge E0 drives its first bit from E1 and its last bit from E(WIDTH), with out_last=1 in that cycle.
- Throughput: with in_valid held high, a new word is accepted every WIDTH cycles and out_valid stays continuously 1.
- in_valid dropping while in_ready=0 has no effect, because no word is taken.

## Test plan
- Reset, then a single word: WIDTH=8, LSB_FIRST=1, in_data=8'hB4 accepted at E0 -> out = 0,0,1,0,1,1,0,1 on E1..E8; out_valid high for 8 cycles; out_last only on E8; IDLE with out=0 from E9.
- Bit order: LSB_FIRST=0, in_data=8'hB4 -> out = 1,0,1,1,0,1,0,0.
- Back-to-back: 8'hFF and 8'h00 offered with in_valid held high -> 16 consecutive out_valid cycles, out_last at the 8th and 16th bits, in_ready low from E1 until the first reload.
- Backpressure: in_valid held high with three words queued -> exactly one accept per 8 cycles, no word lost or duplicated, words appear in order.
- Async reset mid-word: rst_n low between edges during bit 3 of 8'hA5 -> out, out_valid, and out_last are 0 at once and in_ready=1; after release, the next accepted word 8'h3C shifts cleanly from bit 0.
- Minimum width: WIDTH=2, words 2'b01 and 2'b10 back-to-back -> out=1,0,0,1 and out_last on the 2nd and 4th cycles.
